// File: rtl/pwm_multi_ch_if.sv
// ---------------------------------------------------------------------------
// pwm_multi_ch_if
// Bundle of run-control, update-handshake and status signals for
// pwm_multi_ch.
//   master : drives EN, PERIOD_Set, DUTY_Set, POL_Set, UPD_Req;
//            observes UPD_Pend, UPD_Ack, PERIOD_Tick, CNT_Val, PWM_Out
//   slave  : the PWM block itself (mirror directions)
// ---------------------------------------------------------------------------
interface pwm_multi_ch_if #(
    parameter int NCH   = 4,
    parameter int CNT_W = 16
) ();
    logic                   EN;
    logic [CNT_W-1:0]       PERIOD_Set;
    logic [NCH*CNT_W-1:0]   DUTY_Set;
    logic [NCH-1:0]         POL_Set;
    logic                   UPD_Req;
    logic                   UPD_Pend;
    logic                   UPD_Ack;
    logic                   PERIOD_Tick;
    logic [CNT_W-1:0]       CNT_Val;
    logic [NCH-1:0]         PWM_Out;

    modport master (
        output EN, PERIOD_Set, DUTY_Set, POL_Set, UPD_Req,
        input  UPD_Pend, UPD_Ack, PERIOD_Tick, CNT_Val, PWM_Out
    );

    modport slave (
        input  EN, PERIOD_Set, DUTY_Set, POL_Set, UPD_Req,
        output UPD_Pend, UPD_Ack, PERIOD_Tick, CNT_Val, PWM_Out
    );
endinterface

// File: rtl/pwm_multi_ch.sv
// ---------------------------------------------------------------------------
// pwm_multi_ch
// N-channel PWM generator sharing one period counter. Period, per-channel
// duty and polarity are double-buffered: UPD_Req captures them into a shadow
// set, which is committed to the active set only at a period boundary (or
// immediately while stopped), so outputs never glitch mid-period.
//   CLK  : clock
//   RST  : synchronous reset, active-high, highest priority
//   bus  : pwm_multi_ch_if.slave
//          EN          run enable
//          PERIOD_Set  period minus one
//          DUTY_Set    packed duties, channel i at [i*CNT_W +: CNT_W]
//          POL_Set     per-channel active level
//          UPD_Req     level-sampled capture request
//          UPD_Pend    shadow holds an uncommitted update
//          UPD_Ack     one-cycle pulse on commit
//          PERIOD_Tick one-cycle pulse on the first cycle of each period
//          CNT_Val     current counter value
//          PWM_Out     PWM outputs, aligned with CNT_Val
// ---------------------------------------------------------------------------
module pwm_multi_ch #(
    parameter int               NCH     = 4,
    parameter int               CNT_W   = 16,
    parameter logic [NCH-1:0]   POL_RST = '0
) (
    input  logic            CLK,
    input  logic            RST,
    pwm_multi_ch_if.slave   bus
);

    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic [CNT_W-1:0]       period_reg, period_next;
    logic [NCH*CNT_W-1:0]   duty_reg, duty_next;
    logic [NCH-1:0]         pol_reg, pol_next;
    logic [CNT_W-1:0]       period_sh_reg, period_sh_next;
    logic [NCH*CNT_W-1:0]   duty_sh_reg, duty_sh_next;
    logic [NCH-1:0]         pol_sh_reg, pol_sh_next;
    logic                   pend_reg, pend_next;
    logic                   ack_reg, ack_next;
    logic                   tick_reg, tick_next;
    logic [NCH-1:0]         pwm_reg, pwm_next;
    logic                   en_reg;
    logic                   start;
    logic                   boundary;

    always_comb begin
        // A new period starts on the first enabled edge after a stop, and
        // on every wrap. The >= compare also pulls a counter left above a
        // freshly shrunk period back to zero.
        start    = bus.EN && (!en_reg || (cnt_reg >= period_reg));
        // Commits are allowed at a period start, or on any edge while
        // stopped.
        boundary = !bus.EN || start;

        period_next    = period_reg;
        duty_next      = duty_reg;
        pol_next       = pol_reg;
        period_sh_next = period_sh_reg;
        duty_sh_next   = duty_sh_reg;
        pol_sh_next    = pol_sh_reg;
        pend_next      = pend_reg;
        ack_next       = 1'b0;

        if (bus.UPD_Req && boundary) begin
            // Request coincides with a commit opportunity: bypass the shadow.
            period_next = bus.PERIOD_Set;
            duty_next   = bus.DUTY_Set;
            pol_next    = bus.POL_Set;
            pend_next   = 1'b0;
            ack_next    = 1'b1;
        end else if (bus.UPD_Req) begin
            // Later requests simply overwrite an already pending update.
            period_sh_next = bus.PERIOD_Set;
            duty_sh_next   = bus.DUTY_Set;
            pol_sh_next    = bus.POL_Set;
            pend_next      = 1'b1;
        end else if (boundary && pend_reg) begin
            period_next = period_sh_reg;
            duty_next   = duty_sh_reg;
            pol_next    = pol_sh_reg;
            pend_next   = 1'b0;
            ack_next    = 1'b1;
        end

        cnt_next  = (start || !bus.EN) ? '0 : cnt_reg + CNT_W'(1);
        tick_next = start;
    end

    // Outputs are computed from the post-edge counter and the post-commit
    // active values, so the first cycle of a new period already uses them.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            assign pwm_next[gi] =
                (bus.EN && (cnt_next < duty_next[gi*CNT_W +: CNT_W]))
                    ? pol_next[gi] : ~pol_next[gi];
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_reg       <= '0;
            period_reg    <= '0;
            duty_reg      <= '0;
            pol_reg       <= POL_RST;
            period_sh_reg <= '0;
            duty_sh_reg   <= '0;
            pol_sh_reg    <= '0;
            pend_reg      <= 1'b0;
            ack_reg       <= 1'b0;
            tick_reg      <= 1'b0;
            pwm_reg       <= ~POL_RST;
            en_reg        <= 1'b0;
        end else begin
            cnt_reg       <= cnt_next;
            period_reg    <= period_next;
            duty_reg      <= duty_next;
            pol_reg       <= pol_next;
            period_sh_reg <= period_sh_next;
            duty_sh_reg   <= duty_sh_next;
            pol_sh_reg    <= pol_sh_next;
            pend_reg      <= pend_next;
            ack_reg       <= ack_next;
            tick_reg      <= tick_next;
            pwm_reg       <= pwm_next;
            en_reg        <= bus.EN;
        end
    end

    assign bus.CNT_Val     = cnt_reg;
    assign bus.UPD_Pend    = pend_reg;
    assign bus.UPD_Ack     = ack_reg;
    assign bus.PERIOD_Tick = tick_reg;
    assign bus.PWM_Out     = pwm_reg;

endmodule

// File: tb/tb_pwm_multi_ch.sv
// ---------------------------------------------------------------------------
// tb_pwm_multi_ch
// Bench for pwm_multi_ch with NCH=3, CNT_W=8, POL_RST=0. Directed scenarios
// plus a randomized run, all compared every cycle against a behavioural
// model expressed as "position within the current period" and a single
// latest-captured update slot.
// ---------------------------------------------------------------------------
module tb_pwm_multi_ch;
    localparam int NCH = 3;
    localparam int CW  = 8;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    pwm_multi_ch_if #(.NCH(NCH), .CNT_W(CW)) bus ();

    pwm_multi_ch #(.NCH(NCH), .CNT_W(CW), .POL_RST(3'b000)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model state.
    int       m_pos;
    bit       m_running;
    int       m_period;
    int       m_duty [NCH];
    bit [2:0] m_pol;
    bit       m_have;
    int       s_period;
    int       s_duty [NCH];
    bit [2:0] s_pol;
    bit       m_ack;
    bit       m_tick;

    task automatic model_step();
        bit restart;
        bit can_commit;
        if (RST) begin
            m_pos = 0; m_running = 0; m_period = 0; m_pol = 3'b000;
            m_have = 0; m_ack = 0; m_tick = 0;
            s_period = 0; s_pol = 0;
            for (int i = 0; i < NCH; i++) begin
                m_duty[i] = 0; s_duty[i] = 0;
            end
            return;
        end
        restart    = bus.EN && (!m_running || m_pos >= m_period);
        can_commit = !bus.EN || restart;
        if (bus.UPD_Req) begin
            s_period = int'(bus.PERIOD_Set);
            for (int i = 0; i < NCH; i++) s_duty[i] = int'(bus.DUTY_Set[i*CW +: CW]);
            s_pol  = bus.POL_Set;
            m_have = 1;
        end
        m_ack = 0;
        if (can_commit && m_have) begin
            m_period = s_period;
            for (int i = 0; i < NCH; i++) m_duty[i] = s_duty[i];
            m_pol  = s_pol;
            m_have = 0;
            m_ack  = 1;
        end
        if (bus.EN) begin
            m_tick    = restart;
            m_pos     = restart ? 0 : m_pos + 1;
            m_running = 1;
        end else begin
            m_tick = 0; m_pos = 0; m_running = 0;
        end
    endtask

    function automatic logic [13:0] exp_vec();
        logic [2:0] p;
        logic [7:0] c;
        for (int i = 0; i < NCH; i++)
            p[i] = (m_running && m_pos < m_duty[i]) ? m_pol[i] : ~m_pol[i];
        c = m_pos[7:0];
        return {m_have, m_ack, m_tick, c, p};
    endfunction

    function automatic logic [13:0] dut_vec();
        return {bus.UPD_Pend, bus.UPD_Ack, bus.PERIOD_Tick, bus.CNT_Val, bus.PWM_Out};
    endfunction

    task automatic clk_step();
        @(posedge CLK);
        model_step();
        cyc++;
        #1;
    endtask

    task automatic set_cfg(input logic [7:0] per, input logic [7:0] d2,
                           input logic [7:0] d1, input logic [7:0] d0,
                           input logic [2:0] pol);
        bus.PERIOD_Set = per;
        bus.DUTY_Set   = {d2, d1, d0};
        bus.POL_Set    = pol;
    endtask

    task automatic test_reset();
        RST = 1; bus.EN = 0; bus.UPD_Req = 0;
        set_cfg(8'd0, 8'd0, 8'd0, 8'd0, 3'b000);
        repeat (3) clk_step();
        RST = 0;
        clk_step();
        n_checks++;
        if ({bus.PWM_Out, bus.CNT_Val, bus.UPD_Pend, bus.UPD_Ack, bus.PERIOD_Tick} !== {3'b111, 8'd0, 3'b000})
            $display("FAIL reset_state got pwm=%b cnt=%0d pend=%b ack=%b tick=%b want pwm=111 cnt=0 pend=0 ack=0 tick=0",
                     bus.PWM_Out, bus.CNT_Val, bus.UPD_Pend, bus.UPD_Ack, bus.PERIOD_Tick);
        else n_pass++;
        n_checks++;
        if (dut_vec() !== exp_vec()) $display("FAIL reset_model got=%h want=%h", dut_vec(), exp_vec());
        else n_pass++;
        $display("reset: pwm=%b cnt=%0d", bus.PWM_Out, bus.CNT_Val);
    endtask

    task automatic test_basic();
        int c;
        set_cfg(8'd9, 8'd10, 8'd5, 8'd0, 3'b111);
        bus.UPD_Req = 1;
        clk_step();
        bus.UPD_Req = 0;
        n_checks++;
        if ({bus.UPD_Ack, bus.UPD_Pend} !== 2'b10)
            $display("FAIL basic_stopped_commit got ack=%b pend=%b want ack=1 pend=0", bus.UPD_Ack, bus.UPD_Pend);
        else n_pass++;
        bus.EN = 1;
        for (int k = 0; k < 25; k++) begin
            clk_step();
            c = k % 10;
            n_checks++;
            if ({bus.CNT_Val, bus.PWM_Out, bus.PERIOD_Tick} !== {c[7:0], 1'b1, (c < 5), 1'b0, (c == 0)})
                $display("FAIL basic_run k=%0d got cnt=%0d pwm=%b tick=%b want cnt=%0d pwm=1%b0 tick=%b",
                         k, bus.CNT_Val, bus.PWM_Out, bus.PERIOD_Tick, c, (c < 5), (c == 0));
            else n_pass++;
            n_checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL basic_model k=%0d got=%h want=%h", k, dut_vec(), exp_vec());
            else n_pass++;
        end
        $display("basic: 25 cycles at period 10");
    endtask

    task automatic test_mid_update();
        for (int n = 0; n < 20 && m_pos != 3; n++) clk_step();
        n_checks++;
        if (bus.CNT_Val !== 8'd3) $display("FAIL mid_reach3 got cnt=%0d want 3", bus.CNT_Val);
        else n_pass++;
        set_cfg(8'd9, 8'd10, 8'd2, 8'd0, 3'b111);
        bus.UPD_Req = 1;
        clk_step();
        bus.UPD_Req = 0;
        for (int k = 4; k <= 9; k++) begin
            if (k > 4) clk_step();
            n_checks++;
            if ({bus.CNT_Val, bus.UPD_Pend, bus.UPD_Ack, bus.PWM_Out[1]} !== {k[7:0], 1'b1, 1'b0, (k < 5)})
                $display("FAIL mid_pending k=%0d got cnt=%0d pend=%b ack=%b ch1=%b want pend=1 ack=0 ch1=%b",
                         k, bus.CNT_Val, bus.UPD_Pend, bus.UPD_Ack, bus.PWM_Out[1], (k < 5));
            else n_pass++;
        end
        clk_step();
        n_checks++;
        if ({bus.CNT_Val, bus.UPD_Ack, bus.UPD_Pend, bus.PWM_Out[1]} !== {8'd0, 1'b1, 1'b0, 1'b1})
            $display("FAIL mid_commit got cnt=%0d ack=%b pend=%b ch1=%b want cnt=0 ack=1 pend=0 ch1=1",
                     bus.CNT_Val, bus.UPD_Ack, bus.UPD_Pend, bus.PWM_Out[1]);
        else n_pass++;
        for (int k = 1; k <= 9; k++) begin
            clk_step();
            n_checks++;
            if ({bus.PWM_Out[1], bus.UPD_Ack} !== {(k < 2), 1'b0})
                $display("FAIL mid_newduty k=%0d got ch1=%b ack=%b want ch1=%b ack=0",
                         k, bus.PWM_Out[1], bus.UPD_Ack, (k < 2));
            else n_pass++;
            n_checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL mid_model k=%0d got=%h want=%h", k, dut_vec(), exp_vec());
            else n_pass++;
        end
        $display("mid_update: duty ch1 5->2 committed at wrap");
    endtask

    task automatic test_boundary_update();
        int c;
        for (int n = 0; n < 20 && m_pos != 9; n++) clk_step();
        set_cfg(8'd3, 8'd10, 8'd2, 8'd0, 3'b111);
        bus.UPD_Req = 1;
        clk_step();
        bus.UPD_Req = 0;
        n_checks++;
        if ({bus.UPD_Ack, bus.UPD_Pend, bus.CNT_Val} !== {1'b1, 1'b0, 8'd0})
            $display("FAIL boundary_direct got ack=%b pend=%b cnt=%0d want ack=1 pend=0 cnt=0",
                     bus.UPD_Ack, bus.UPD_Pend, bus.CNT_Val);
        else n_pass++;
        for (int k = 1; k <= 8; k++) begin
            clk_step();
            c = k % 4;
            n_checks++;
            if ({bus.CNT_Val, bus.PERIOD_Tick} !== {c[7:0], (c == 0)})
                $display("FAIL boundary_period4 k=%0d got cnt=%0d tick=%b want cnt=%0d tick=%b",
                         k, bus.CNT_Val, bus.PERIOD_Tick, c, (c == 0));
            else n_pass++;
        end
        $display("boundary_update: period 10->4 with no pending phase");
    endtask

    task automatic test_extremes();
        int highs;
        set_cfg(8'd0, 8'd0, 8'd0, 8'd1, 3'b111);
        bus.UPD_Req = 1;
        clk_step();
        bus.UPD_Req = 0;
        for (int n = 0; n < 8 && bus.UPD_Ack !== 1'b1; n++) clk_step();
        n_checks++;
        if (bus.UPD_Ack !== 1'b1) $display("FAIL extremes_ack_timeout got ack=%b want 1", bus.UPD_Ack);
        else n_pass++;
        for (int k = 0; k < 6; k++) begin
            clk_step();
            n_checks++;
            if ({bus.PERIOD_Tick, bus.PWM_Out, bus.CNT_Val} !== {1'b1, 3'b001, 8'd0})
                $display("FAIL extremes_p0 k=%0d got tick=%b pwm=%b cnt=%0d want tick=1 pwm=001 cnt=0",
                         k, bus.PERIOD_Tick, bus.PWM_Out, bus.CNT_Val);
            else n_pass++;
        end
        set_cfg(8'd255, 8'd0, 8'd0, 8'd255, 3'b111);
        bus.UPD_Req = 1;
        clk_step();
        bus.UPD_Req = 0;
        n_checks++;
        if ({bus.UPD_Ack, bus.UPD_Pend} !== 2'b10)
            $display("FAIL extremes_p255_commit got ack=%b pend=%b want ack=1 pend=0", bus.UPD_Ack, bus.UPD_Pend);
        else n_pass++;
        highs = int'(bus.PWM_Out[0]);
        for (int k = 1; k < 256; k++) begin
            clk_step();
            highs += int'(bus.PWM_Out[0]);
            n_checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL extremes_model k=%0d got=%h want=%h", k, dut_vec(), exp_vec());
            else n_pass++;
        end
        n_checks++;
        if (highs !== 255) $display("FAIL extremes_duty255 got high=%0d want 255", highs);
        else n_pass++;
        $display("extremes: period 1 tick-always, period 256 duty 255 high=%0d", highs);
    endtask

    task automatic test_en_drop_and_reset();
        set_cfg(8'd9, 8'd10, 8'd5, 8'd0, 3'b010);
        bus.UPD_Req = 1;
        clk_step();
        bus.UPD_Req = 0;
        for (int n = 0; n < 300 && bus.UPD_Ack !== 1'b1; n++) begin
            clk_step();
            n_checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL endrop_wait_model got=%h want=%h", dut_vec(), exp_vec());
            else n_pass++;
        end
        n_checks++;
        if (bus.UPD_Ack !== 1'b1) $display("FAIL endrop_ack_timeout got ack=%b want 1", bus.UPD_Ack);
        else n_pass++;
        for (int n = 0; n < 20 && m_pos != 4; n++) clk_step();
        bus.EN = 0;
        clk_step();
        n_checks++;
        if ({bus.CNT_Val, bus.PWM_Out, bus.PERIOD_Tick} !== {8'd0, 3'b101, 1'b0})
            $display("FAIL endrop_outputs got cnt=%0d pwm=%b tick=%b want cnt=0 pwm=101 tick=0",
                     bus.CNT_Val, bus.PWM_Out, bus.PERIOD_Tick);
        else n_pass++;
        bus.EN = 1;
        for (int n = 0; n < 20 && !(m_running && m_pos == 2); n++) clk_step();
        set_cfg(8'd5, 8'd1, 8'd1, 8'd1, 3'b111);
        bus.UPD_Req = 1;
        clk_step();
        bus.UPD_Req = 0;
        n_checks++;
        if (bus.UPD_Pend !== 1'b1) $display("FAIL rst_pending_setup got pend=%b want 1", bus.UPD_Pend);
        else n_pass++;
        RST = 1;
        clk_step();
        RST = 0;
        n_checks++;
        if ({bus.UPD_Pend, bus.UPD_Ack, bus.PERIOD_Tick, bus.CNT_Val, bus.PWM_Out} !== {3'b000, 8'd0, 3'b111})
            $display("FAIL rst_midperiod got pend=%b ack=%b tick=%b cnt=%0d pwm=%b want 0 0 0 0 111",
                     bus.UPD_Pend, bus.UPD_Ack, bus.PERIOD_Tick, bus.CNT_Val, bus.PWM_Out);
        else n_pass++;
        for (int k = 0; k < 12; k++) begin
            clk_step();
            n_checks++;
            if ({bus.UPD_Ack, bus.PERIOD_Tick, bus.PWM_Out} !== {1'b0, 1'b1, 3'b111})
                $display("FAIL rst_discard k=%0d got ack=%b tick=%b pwm=%b want ack=0 tick=1 pwm=111",
                         k, bus.UPD_Ack, bus.PERIOD_Tick, bus.PWM_Out);
            else n_pass++;
        end
        $display("en_drop_and_reset: pwm after drop and reset checked");
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            RST         = ($urandom_range(0, 149) == 0);
            bus.EN      = ($urandom_range(0, 9) != 0);
            bus.UPD_Req = ($urandom_range(0, 5) == 0);
            set_cfg(8'($urandom_range(0, 12)), 8'($urandom_range(0, 14)),
                    8'($urandom_range(0, 14)), 8'($urandom_range(0, 14)), 3'($urandom));
            clk_step();
            n_checks++;
            if (dut_vec() !== exp_vec())
                $display("FAIL random_model k=%0d got=%h want=%h", k, dut_vec(), exp_vec());
            else n_pass++;
        end
        RST = 0; bus.UPD_Req = 0;
        $display("random: 600 cycles compared");
    endtask

    initial begin
        bus.EN = 0; bus.UPD_Req = 0;
        set_cfg(8'd0, 8'd0, 8'd0, 8'd0, 3'b000);
        test_reset();
        test_basic();
        test_mid_update();
        test_boundary_update();
        test_extremes();
        test_en_drop_and_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d got no finish want finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule
